// File: rtl/uart_rx_frame.sv
// 8N1 serial receiver: synchronises rs232_rx, centre-samples each bit with a baud
// counter and reports each byte on the falling edge of rx_int.
module uart_rx_frame #(
    parameter int CLK_HZ   = 50000000,
    parameter int BAUD     = 9600,
    parameter int BAUD_DIV = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_int,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic             stop_taken, stop_taken_nxt;
    logic             stop_bit, stop_bit_nxt;
    logic [7:0]       rx_data_nxt;
    logic             rx_int_nxt, rx_valid_nxt, frame_err_nxt;

    logic sync_p0, sync_p1, prev_p2;
    logic line_fall;

    // p0/p1: metastability synchroniser; p2: previous sample for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
        end else begin
            sync_p0 <= rs232_rx;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign line_fall = prev_p2 & ~sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            stop_taken <= 1'b0;
            stop_bit   <= 1'b0;
            rx_data    <= 8'h00;
            rx_int     <= 1'b0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift_reg  <= shift_nxt;
            stop_taken <= stop_taken_nxt;
            stop_bit   <= stop_bit_nxt;
            rx_data    <= rx_data_nxt;
            rx_int     <= rx_int_nxt;
            rx_valid   <= rx_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        bit_idx_nxt    = bit_idx;
        shift_nxt      = shift_reg;
        stop_taken_nxt = stop_taken;
        stop_bit_nxt   = stop_bit;
        rx_data_nxt    = rx_data;
        rx_int_nxt     = rx_int;
        rx_valid_nxt   = 1'b0;
        frame_err_nxt  = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (line_fall) state_nxt = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    if (!sync_p1) begin
                        rx_int_nxt  = 1'b1;
                        bit_idx_nxt = '0;
                        state_nxt   = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    shift_nxt   = {sync_p1, shift_reg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                // Stop bit is captured first; the byte is published one cycle later.
                if (stop_taken) begin
                    stop_taken_nxt = 1'b0;
                    rx_data_nxt    = shift_reg;
                    rx_int_nxt     = 1'b0;
                    if (stop_bit) begin
                        rx_valid_nxt = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = BREAK;
                    end
                end else if (cnt == CNT_LAST) begin
                    stop_taken_nxt = 1'b1;
                    stop_bit_nxt   = sync_p1;
                end
            end
            BREAK: begin
                cnt_nxt = '0;
                if (sync_p1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state) cnt_nxt = '0;
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: serial frames are driven bit by bit, expected bytes queued
// at send time and checked on each rx_int fall; a second instance uses default params.
module tb_uart_rx_frame;

    localparam int N     = 16;
    localparam int NBIG  = 5208;
    localparam int RISE  = 3 + N / 2;             // edges from start-bit drive: 2 sync + 1 detect
    localparam int FALL  = 3 + N / 2 + 9 * N + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic       rx_line_big = 1'b1;
    logic [7:0] rx_data, rx_data_big;
    logic       rx_int, rx_valid, frame_err;
    logic       rx_int_big, rx_valid_big, frame_err_big;

    always #5 clk = ~clk;

    uart_rx_frame #(.CLK_HZ(16), .BAUD(1)) u_dut (
        .clk(clk), .rst(rst), .rs232_rx(rx_line),
        .rx_data(rx_data), .rx_int(rx_int), .rx_valid(rx_valid), .frame_err(frame_err)
    );

    uart_rx_frame u_big (
        .clk(clk), .rst(rst), .rs232_rx(rx_line_big),
        .rx_data(rx_data_big), .rx_int(rx_int_big), .rx_valid(rx_valid_big),
        .frame_err(frame_err_big)
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    logic int_d = 1'b0;
    logic [7:0] last_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor for the N=16 instance, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            int_d     = rx_int;
            last_data = rx_data;
        end else begin
            if (!int_d && rx_int) begin
                rise_cnt++;
                check("rise_latency", cyc - start_cyc, RISE);
            end
            if (int_d && !rx_int) begin
                fall_cnt++;
                check("fall_latency", cyc - start_cyc, FALL);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", int'(rx_data), int'(e.data));
                    check("rx_valid", int'(rx_valid), int'(!e.err));
                    check("frame_err", int'(frame_err), int'(e.err));
                end
                last_data = rx_data;
            end else begin
                check("stray_pulse", int'(rx_valid | frame_err), 0);
                check("rx_data_stable", int'(rx_data), int'(last_data));
            end
            int_d = rx_int;
        end
    end

    // Caller keeps time aligned at 1 unit after a rising edge.
    task automatic hold(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit big, input logic v);
        if (big) rx_line_big = v;
        else     rx_line = v;
    endtask

    task automatic send_byte(input bit big, input logic [7:0] d, input logic stop);
        int n;
        n = big ? NBIG : N;
        if (!big) start_cyc = cyc;
        drive(big, 1'b0);
        hold(n);
        for (int i = 0; i < 8; i++) begin
            drive(big, d[i]);
            hold(n);
        end
        drive(big, stop);
        hold(n);
    endtask

    task automatic idle(input int g);
        rx_line = 1'b1;
        hold(g);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    vec_t vecs[7];

    initial begin
        int r0, f0;
        logic [7:0] d0;
        int k;
        bit seen;

        vecs[0] = '{8'h55, 1'b1, 20, 8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b1,  0, 8'hA3, 1'b0};
        vecs[2] = '{8'h0F, 1'b1, 20, 8'h0F, 1'b0};
        vecs[3] = '{8'h00, 1'b1,  4, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b1,  4, 8'hFF, 1'b0};
        vecs[5] = '{8'h80, 1'b1,  0, 8'h80, 1'b0};
        vecs[6] = '{8'h01, 1'b1, 20, 8'h01, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_int", int'(rx_int), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_big_rx_int", int'(rx_int_big), 0);
        rst = 1'b0;
        hold(10);

        // Frame table, including back-to-back pairs
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_err});
            send_byte(1'b0, vecs[i].data, vecs[i].stop);
            idle(vecs[i].gap);
        end
        idle(2 * N);
        wait_drain("table_drain");
        check("table_frames", fall_cnt, 7);

        // Glitch shorter than half a bit
        r0 = rise_cnt;
        f0 = fall_cnt;
        d0 = rx_data;
        start_cyc = cyc;
        rx_line = 1'b0;
        hold(5);
        idle(3 * N);
        check("glitch_no_rise", rise_cnt, r0);
        check("glitch_no_fall", fall_cnt, f0);
        check("glitch_rx_data", int'(rx_data), int'(d0));

        // Framing error, long low hold, then a good frame
        exp_q.push_back('{8'h3C, 1'b1});
        send_byte(1'b0, 8'h3C, 1'b0);
        hold(40);
        f0 = fall_cnt;
        check("break_rx_data", int'(rx_data), 8'h3C);
        idle(2 * N);
        check("break_no_frame", fall_cnt, f0);
        exp_q.push_back('{8'h81, 1'b0});
        send_byte(1'b0, 8'h81, 1'b1);
        idle(2 * N);
        wait_drain("break_drain");

        // Reset during bit 4 of 0xFF, then a normal frame
        fork
            send_byte(1'b0, 8'hFF, 1'b1);
            begin
                hold(5 * N + N / 2);
                check("pre_rst_busy", int'(rx_int), 1);
                rst = 1'b1;
                hold(1);
                check("midrst_rx_data", int'(rx_data), 0);
                check("midrst_rx_int", int'(rx_int), 0);
                check("midrst_rx_valid", int'(rx_valid), 0);
                check("midrst_frame_err", int'(frame_err), 0);
                hold(1);
                rst = 1'b0;
            end
        join
        idle(2 * N);
        exp_q.push_back('{8'h12, 1'b0});
        send_byte(1'b0, 8'h12, 1'b1);
        idle(2 * N);
        wait_drain("post_rst_drain");

        // Default-parameter instance
        k = 0;
        seen = 1'b0;
        fork
            send_byte(1'b1, 8'hC9, 1'b1);
            begin
                while (k < 60000) begin
                    @(posedge clk);
                    #1;
                    k++;
                    if (rx_int_big && !seen) begin
                        seen = 1'b1;
                        check("big_rise_latency", k, 3 + NBIG / 2);
                    end
                    if (seen && !rx_int_big) break;
                end
                check("big_fall_latency", k, 3 + NBIG / 2 + 9 * NBIG + 1);
                check("big_rx_data", int'(rx_data_big), 8'hC9);
                check("big_rx_valid", int'(rx_valid_big), 1);
                check("big_frame_err", int'(frame_err_big), 0);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
